uart_frame_tx: RTL

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx.sv | 78 +++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises a FRAME_BYTES-character payload as 8N1-style UART characters, LSB first
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DBITS        = 8,
  parameter int FRAME_BYTES  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DBITS*FRAME_BYTES-1:0] frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int FW = DBITS * FRAME_BYTES;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DBITS > 1 ? $clog2(DBITS) : 1;
  localparam int YW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bit_idx, bit_idx_d;
  logic [YW-1:0] byte_idx, byte_idx_d;
  logic [FW-1:0] sreg, sreg_d;
  logic tx_d, done_d, cnt_last, bit_last, byte_last;
  assign frame_ready = state == IDLE;
  assign busy = !frame_ready;
  always_comb begin
    cnt_last = cnt == CW'(CLKS_PER_BIT - 1);
    bit_last = bit_idx == BW'(DBITS - 1);
    byte_last = byte_idx == YW'(FRAME_BYTES - 1);
    state_d = state;
    sreg_d = sreg;
    bit_idx_d = bit_idx;
    byte_idx_d = byte_idx;
    cnt_d = (state == IDLE || cnt_last) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (frame_valid) begin
        state_d = START;
        sreg_d = frame_data;
        bit_idx_d = '0;
        byte_idx_d = '0;
      end
      START: if (cnt_last) state_d = DATA;
      DATA: if (cnt_last) begin
        sreg_d = sreg >> 1;
        bit_idx_d = bit_last ? '0 : bit_idx + 1'b1;
        state_d = bit_last ? STOP : DATA;
      end
      STOP: if (cnt_last) begin
        state_d = byte_last ? IDLE : START;
        byte_idx_d = byte_last ? '0 : byte_idx + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sreg_d[0] : 1'b1;
    done_d = state == STOP && cnt_last && byte_last;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sreg <= '0;
      tx <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_idx <= bit_idx_d;
      byte_idx <= byte_idx_d;
      sreg <= sreg_d;
      tx <= tx_d;
      frame_done <= done_d;
    end
endmodule
